// File: rtl/jump_resolve_ras.sv
// jump_resolve_ras: JAL/JALR decode, target and link computation, and
// return prediction through a circular return-address stack (RAS).
// A single registered result stage with a valid/ready handshake sits on the
// output. The RAS is updated speculatively when an instruction is accepted.
module jump_resolve_ras #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction_code,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rd,
    output logic [1:0]      jump_control,
    output logic [XLEN-1:0] link_addr,
    output logic [XLEN-1:0] target_addr,
    output logic            ras_pred_valid,
    output logic [XLEN-1:0] ras_pred_addr,
    output logic            mispredict
);

    localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpJalr = 7'b1100111;

    localparam logic [1:0] JcNone = 2'b00;
    localparam logic [1:0] JcJal  = 2'b01;
    localparam logic [1:0] JcJalr = 2'b10;

    localparam logic [XLEN-1:0] InstrBytes = XLEN'(4);
    localparam logic [XLEN-1:0] AlignMask  = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [CntW-1:0] CntFull    = CntW'(RAS_DEPTH);
    localparam logic [CntW-1:0] CntOne     = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne     = PtrW'(1);

    typedef enum logic [1:0] {
        RasNone,
        RasPush,
        RasPop,
        RasPopPush
    } ras_op_e;

    // Field extraction
    logic [6:0]      opcode;
    logic [4:0]      rd_idx;
    logic [4:0]      rs1_idx;
    logic            is_jal;
    logic            is_jalr;
    logic            rd_link;
    logic            rs1_link;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] jalr_sum;

    // Decoded result
    logic [1:0]      jc_d;
    logic [XLEN-1:0] link_d;
    logic [XLEN-1:0] target_d;
    ras_op_e         ras_op;
    logic            pred_valid_d;
    logic [XLEN-1:0] pred_addr_d;
    logic            mispredict_d;

    // RAS state
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PtrW-1:0] ras_ptr_q, ras_ptr_d;
    logic [CntW-1:0] ras_cnt_q, ras_cnt_d;
    logic [PtrW-1:0] ras_top_idx;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_we;
    logic [PtrW-1:0] ras_waddr;

    // Output stage
    logic            out_valid_q;
    logic [4:0]      rd_q;
    logic [1:0]      jc_q;
    logic [XLEN-1:0] link_q;
    logic [XLEN-1:0] target_q;
    logic            pred_valid_q;
    logic [XLEN-1:0] pred_addr_q;
    logic            mispredict_q;

    logic            accept;

    assign opcode   = instruction_code[6:0];
    assign rd_idx   = instruction_code[11:7];
    assign rs1_idx  = instruction_code[19:15];
    assign is_jal   = (opcode == OpJal);
    assign is_jalr  = (opcode == OpJalr);
    assign rd_link  = (rd_idx == 5'd1) || (rd_idx == 5'd5);
    assign rs1_link = (rs1_idx == 5'd1) || (rs1_idx == 5'd5);

    assign imm_j = {{(XLEN-21){instruction_code[31]}}, instruction_code[31],
                    instruction_code[19:12], instruction_code[20],
                    instruction_code[30:21], 1'b0};
    assign imm_i = {{(XLEN-12){instruction_code[31]}}, instruction_code[31:20]};

    assign jalr_sum = rs1_data + imm_i;
    assign link_d   = pc + InstrBytes;

    // ras_ptr_q is the next free slot; the top entry sits just below it.
    assign ras_top_idx = ras_ptr_q - PtrOne;
    assign ras_top     = ras_mem[ras_top_idx];
    assign ras_empty   = (ras_cnt_q == '0);
    assign ras_full    = (ras_cnt_q == CntFull);

    // Result stage frees up when empty or draining; flush blocks new work.
    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Decode: jump kind, target, and the RAS action implied by rd/rs1 hints
    always_comb begin
        jc_d     = JcNone;
        target_d = '0;
        ras_op   = RasNone;
        if (is_jal) begin
            jc_d     = JcJal;
            target_d = pc + imm_j;
            if (rd_link) begin
                ras_op = RasPush;
            end
        end else if (is_jalr) begin
            jc_d     = JcJalr;
            target_d = jalr_sum & AlignMask;
            case ({rd_link, rs1_link})
                2'b10:   ras_op = RasPush;
                2'b01:   ras_op = RasPop;
                2'b11:   ras_op = (rd_idx == rs1_idx) ? RasPush : RasPopPush;
                default: ras_op = RasNone;
            endcase
        end
    end

    // RAS prediction and next pointer/count; state only moves on accept
    always_comb begin
        pred_valid_d = 1'b0;
        pred_addr_d  = '0;
        ras_ptr_d    = ras_ptr_q;
        ras_cnt_d    = ras_cnt_q;
        ras_we       = 1'b0;
        ras_waddr    = ras_ptr_q;
        case (ras_op)
            RasPush: begin
                ras_we    = 1'b1;
                ras_ptr_d = ras_ptr_q + PtrOne;
                // Wrapping pointer overwrites the oldest entry when full.
                ras_cnt_d = ras_full ? ras_cnt_q : ras_cnt_q + CntOne;
            end
            RasPop: begin
                if (!ras_empty) begin
                    pred_valid_d = 1'b1;
                    pred_addr_d  = ras_top;
                    ras_ptr_d    = ras_top_idx;
                    ras_cnt_d    = ras_cnt_q - CntOne;
                end
            end
            RasPopPush: begin
                if (!ras_empty) begin
                    // Coroutine swap: predict from old top, then replace it.
                    pred_valid_d = 1'b1;
                    pred_addr_d  = ras_top;
                    ras_we       = 1'b1;
                    ras_waddr    = ras_top_idx;
                end else begin
                    // Nothing to pop, so this degenerates to a plain push.
                    ras_we    = 1'b1;
                    ras_ptr_d = ras_ptr_q + PtrOne;
                    ras_cnt_d = ras_cnt_q + CntOne;
                end
            end
            default: ;
        endcase
        if (!accept) begin
            ras_ptr_d = ras_ptr_q;
            ras_cnt_d = ras_cnt_q;
            ras_we    = 1'b0;
        end
    end

    assign mispredict_d = pred_valid_d && (pred_addr_d != target_d);

    // RAS pointer and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    // RAS storage; contents are meaningless until pushed, so no reset
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_mem[ras_waddr] <= link_d;
        end
    end

    // Result register: load on accept, otherwise drain or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            rd_q         <= '0;
            jc_q         <= '0;
            link_q       <= '0;
            target_q     <= '0;
            pred_valid_q <= 1'b0;
            pred_addr_q  <= '0;
            mispredict_q <= 1'b0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            rd_q         <= rd_idx;
            jc_q         <= jc_d;
            link_q       <= link_d;
            target_q     <= target_d;
            pred_valid_q <= pred_valid_d;
            pred_addr_q  <= pred_addr_d;
            mispredict_q <= mispredict_d;
        end else if (out_ready || flush) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid      = out_valid_q;
    assign rd             = rd_q;
    assign jump_control   = jc_q;
    assign link_addr      = link_q;
    assign target_addr    = target_q;
    assign ras_pred_valid = pred_valid_q;
    assign ras_pred_addr  = pred_addr_q;
    assign mispredict     = mispredict_q;

endmodule

// File: tb/tb_jump_resolve_ras.sv
// Bench for jump_resolve_ras: directed vector table, hand-written handshake,
// flush and reset sequences, then random traffic against a queue-based model.
module tb_jump_resolve_ras;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction_code;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  rd;
    logic [1:0]  jump_control;
    logic [31:0] link_addr;
    logic [31:0] target_addr;
    logic        ras_pred_valid;
    logic [31:0] ras_pred_addr;
    logic        mispredict;

    jump_resolve_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .instruction_code (instruction_code),
        .pc               (pc),
        .rs1_data         (rs1_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .rd               (rd),
        .jump_control     (jump_control),
        .link_addr        (link_addr),
        .target_addr      (target_addr),
        .ras_pred_valid   (ras_pred_valid),
        .ras_pred_addr    (ras_pred_addr),
        .mispredict       (mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ic;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [1:0]  jc;
        logic [31:0] tgt;
        logic        pv;
        logic [31:0] pa;
        logic        mp;
    } vec_t;

    vec_t        tbl[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] ras_q[$];
    logic        m_valid;
    logic [127:0] m_out;

    localparam logic [31:0] Ret = 32'h0000_8067;
    localparam logic [31:0] Add = 32'h0000_0033;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic [127:0] pk(input logic v, input logic [1:0] jc, input logic [4:0] r,
                                        input logic [31:0] lk, input logic [31:0] tg,
                                        input logic p, input logic [31:0] pa, input logic m);
        return {22'b0, v, jc, r, lk, tg, p, pa, m};
    endfunction

    function automatic logic [127:0] dut_out();
        return {22'b0, out_valid, jump_control, rd, link_addr, target_addr,
                ras_pred_valid, ras_pred_addr, mispredict};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rdn, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rdn, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rdn, input logic [4:0] rsn,
                                             input logic [11:0] imm);
        return {imm, rsn, 3'b000, rdn, 7'h67};
    endfunction

    task automatic add_vec(input logic [31:0] ic, input logic [31:0] p, input logic [31:0] r1,
                           input logic [1:0] jc, input logic [31:0] tg, input logic pv,
                           input logic [31:0] pa, input logic mp);
        vec_t v;
        v = '{ic, p, r1, jc, tg, pv, pa, mp};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic v, input logic [31:0] ic, input logic [31:0] p,
                         input logic [31:0] r1, input logic ordy, input logic fl);
        in_valid         = v;
        instruction_code = ic;
        pc               = p;
        rs1_data         = r1;
        out_ready        = ordy;
        flush            = fl;
    endtask

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    // Reference: spec rules with signed integer arithmetic and a bounded queue.
    task automatic model_accept(input logic [31:0] ic, input logic [31:0] p,
                                input logic [31:0] r1, output logic [127:0] o);
        longint      imm;
        logic [31:0] tgt;
        logic [31:0] pa;
        logic        pv;
        logic [1:0]  jc;
        logic [4:0]  rdn;
        logic [4:0]  rsn;
        logic [31:0] link;
        tgt  = '0;
        pa   = '0;
        pv   = 1'b0;
        jc   = 2'b00;
        rdn  = ic[11:7];
        rsn  = ic[19:15];
        link = p + 32'd4;
        if (ic[6:0] == 7'h6F) begin
            jc  = 2'b01;
            imm = {ic[31], ic[19:12], ic[20], ic[30:21], 1'b0};
            if (ic[31]) imm = imm - (longint'(1) << 21);
            tgt = 32'(longint'(p) + imm);
            if (is_link(rdn)) begin
                ras_q.push_back(link);
                if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
            end
        end else if (ic[6:0] == 7'h67) begin
            jc  = 2'b10;
            imm = ic[31:20];
            if (ic[31]) imm = imm - 4096;
            tgt = 32'(longint'(r1) + imm);
            tgt[0] = 1'b0;
            if (is_link(rdn) && !is_link(rsn)) begin
                ras_q.push_back(link);
                if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
            end else if (!is_link(rdn) && is_link(rsn)) begin
                if (ras_q.size() > 0) begin
                    pv = 1'b1;
                    pa = ras_q.pop_back();
                end
            end else if (is_link(rdn) && is_link(rsn)) begin
                if (rdn != rsn && ras_q.size() > 0) begin
                    pv = 1'b1;
                    pa = ras_q.pop_back();
                end
                ras_q.push_back(link);
                if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
            end
        end
        o = pk(1'b1, jc, rdn, link, tgt, pv, pa, pv && (pa != tgt));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ic;
        logic [4:0]  rdn;
        logic [4:0]  rsn;
        logic [6:0]  op;
        logic        exp_rdy;
        logic [127:0] held;

        rst_n = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_outputs", dut_out(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors; RAS state carries from one entry to the next.
        add_vec(enc_jal(5'd1, 21'd8), 32'h100, 32'h0, 2'b01, 32'h108, 1'b0, 32'h0, 1'b0);
        add_vec(Ret, 32'h200, 32'h104, 2'b10, 32'h104, 1'b1, 32'h104, 1'b0);
        add_vec(enc_jal(5'd1, 21'd8), 32'h100, 32'h0, 2'b01, 32'h108, 1'b0, 32'h0, 1'b0);
        add_vec(Ret, 32'h300, 32'h201, 2'b10, 32'h200, 1'b1, 32'h104, 1'b1);
        for (int k = 0; k < 5; k++)
            add_vec(enc_jal(5'd1, 21'd8), 32'(k * 16), 32'h0, 2'b01, 32'(k * 16 + 8),
                    1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++)
            add_vec(Ret, 32'(32'h1000 + k * 4), 32'(32'h44 - k * 16), 2'b10,
                    32'(32'h44 - k * 16), 1'b1, 32'(32'h44 - k * 16), 1'b0);
        add_vec(Ret, 32'h1010, 32'h4, 2'b10, 32'h4, 1'b0, 32'h0, 1'b0);
        add_vec(Add, 32'h700, 32'h123, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0);
        add_vec(enc_jal(5'd1, 21'd8), 32'h4FC, 32'h0, 2'b01, 32'h504, 1'b0, 32'h0, 1'b0);
        add_vec(enc_jalr(5'd1, 5'd5, 12'h0), 32'h600, 32'h500, 2'b10, 32'h500,
                1'b1, 32'h500, 1'b0);
        add_vec(Ret, 32'h800, 32'h604, 2'b10, 32'h604, 1'b1, 32'h604, 1'b0);
        add_vec(Ret, 32'h810, 32'h10, 2'b10, 32'h10, 1'b0, 32'h0, 1'b0);
        add_vec(enc_jal(5'd0, 21'h1FFFFC), 32'h100, 32'h0, 2'b01, 32'hFC, 1'b0, 32'h0, 1'b0);
        add_vec(enc_jalr(5'd0, 5'd7, 12'hFFE), 32'h900, 32'h1001, 2'b10, 32'hFFE,
                1'b0, 32'h0, 1'b0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(1'b1, tbl[i].ic, tbl[i].pc, tbl[i].rs1, 1'b1, 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), dut_out(),
                pk(1'b1, tbl[i].jc, tbl[i].ic[11:7], 32'(tbl[i].pc + 4), tbl[i].tgt,
                   tbl[i].pv, tbl[i].pa, tbl[i].mp));
        end
        @(negedge clk);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Backpressure: result holds, the waiting return is not taken.
        @(negedge clk);
        drive(1'b1, enc_jal(5'd1, 21'd8), 32'h900, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        held = pk(1'b1, 2'b01, 5'd1, 32'h904, 32'h908, 1'b0, 32'h0, 1'b0);
        chk("bp_first", dut_out(), held);
        @(negedge clk);
        drive(1'b1, Ret, 32'h950, 32'h904, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_in_ready%0d", k), in_ready, 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d", k), dut_out(), held);
            @(negedge clk);
        end
        drive(1'b1, Add, 32'hA00, 32'h0, 1'b1, 1'b0);
        #1;
        chk("bp_release_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("bp_no_bubble", dut_out(), pk(1'b1, 2'b00, 5'd0, 32'hA04, 32'h0, 1'b0, 32'h0, 1'b0));
        @(negedge clk);
        drive(1'b1, Ret, 32'hA10, 32'h904, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("bp_ras_intact", dut_out(),
            pk(1'b1, 2'b10, 5'd0, 32'hA14, 32'h904, 1'b1, 32'h904, 1'b0));
        @(negedge clk);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("drain_valid", out_valid, 1'b0);

        // Flush: clears the result and refuses the instruction presented.
        @(negedge clk);
        drive(1'b1, enc_jal(5'd1, 21'd8), 32'hB00, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("fl_first", dut_out(), pk(1'b1, 2'b01, 5'd1, 32'hB04, 32'hB08, 1'b0, 32'h0, 1'b0));
        @(negedge clk);
        drive(1'b1, Ret, 32'hB50, 32'hB04, 1'b0, 1'b1);
        #1;
        chk("fl_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("fl_valid", out_valid, 1'b0);
        @(negedge clk);
        drive(1'b1, Ret, 32'hB60, 32'hB04, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("fl_ras_intact", dut_out(),
            pk(1'b1, 2'b10, 5'd0, 32'hB64, 32'hB04, 1'b1, 32'hB04, 1'b0));

        // Asynchronous reset mid-hold.
        @(negedge clk);
        drive(1'b1, enc_jal(5'd1, 21'd8), 32'hC00, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_first", dut_out(), pk(1'b1, 2'b01, 5'd1, 32'hC04, 32'hC08, 1'b0, 32'h0, 1'b0));
        @(negedge clk);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", dut_out(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, Ret, 32'hD00, 32'hC04, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_ras_empty", dut_out(),
            pk(1'b1, 2'b10, 5'd0, 32'hD04, 32'hC04, 1'b0, 32'h0, 1'b0));

        // Random traffic against the reference model.
        do_reset();
        ras_q.delete();
        m_valid = 1'b0;
        m_out   = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r   = $urandom();
            rdn = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) :
                  (($urandom_range(1) == 0) ? 5'd1 : 5'd5);
            if ($urandom_range(3) == 0) rdn = 5'd0;
            rsn = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) :
                  (($urandom_range(1) == 0) ? 5'd1 : 5'd5);
            case ($urandom_range(9))
                0, 1, 2, 3: ic = {r[31:12], rdn, 7'h6F};
                4, 5, 6, 7: begin
                    ic = {r[31:20], rsn, r[14:12], rdn, 7'h67};
                    if (r[0]) ic[31:20] = '0;
                end
                default: begin
                    op = r[6:0];
                    if (op == 7'h6F || op == 7'h67) op = 7'h13;
                    ic = {r[31:7], op};
                end
            endcase
            drive($urandom_range(9) < 7, ic, $urandom(), $urandom(),
                  $urandom_range(9) < 7, $urandom_range(9) == 0);
            if (ras_q.size() > 0 && $urandom_range(1) == 0) rs1_data = ras_q[$];
            exp_rdy = !flush && (!m_valid || out_ready);
            #1;
            chk("rnd_in_ready", in_ready, exp_rdy);
            if (in_valid && exp_rdy) begin
                model_accept(instruction_code, pc, rs1_data, m_out);
                m_valid = 1'b1;
            end else if (out_ready || flush) begin
                m_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("rnd_out_valid", out_valid, m_valid);
            if (m_valid) chk($sformatf("rnd_result%0d", c), dut_out(), m_out);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jump_resolve_ras.md
Name: jump_resolve_ras

Overview:
- Next-generation jump handling block: decodes JAL/JALR, computes the jump target and the link address, and predicts returns with a return-address stack (RAS).
- Sits between decode and execute. Has one registered output stage with a valid/ready handshake.
- Width and RAS depth are parametrised. Mispredicts are flagged to the fetch redirect logic.

Parameters:
- XLEN, 32, datapath/address width; legal values 32 or 64.
- RAS_DEPTH, 4, number of RAS entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  instruction presented.
- in_ready  out  1  block can accept.
- instruction_code  in  32  raw instruction.
- pc  in  XLEN  PC of the instruction.
- rs1_data  in  XLEN  rs1 operand value.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- rd  out  5  destination register, instruction_code[11:7].
- jump_control  out  2  2'b00 none, 2'b01 JAL, 2'b10 JALR.
- link_addr  out  XLEN  pc+4.
- target_addr  out  XLEN  resolved target.
- ras_pred_valid  out  1  RAS produced a return prediction.
- ras_pred_addr  out  XLEN  predicted return address.
- mispredict  out  1  prediction present and different from target_addr.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0.
  - RAS top pointer and occupancy count go to 0.
  - RAS entry contents do not need to be reset.
  - Reset mid-transfer discards any held result.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready).
  - An accept occurs when in_valid && in_ready. The result registers load on the same edge, so latency is 1 cycle.
  - While out_valid && !out_ready, all outputs hold stable.
  - When out_ready is high and there is no new accept, out_valid clears.
- flush:
  - Clears out_valid on the next edge.
  - Suppresses an accept in the same cycle.
  - Does not modify the RAS; RAS updates are speculative at accept time.
- Decode (opcode = instruction_code[6:0]):
  - JAL (1101111):
    - imm = {ic[31], ic[19:12], ic[20], ic[30:21], 0}, sign-extended to XLEN.
    - target = pc + imm.
  - JALR (1100111):
    - imm = ic[31:20], sign-extended.
    - target = (rs1_data + imm) with bit 0 cleared.
  - Any other opcode:
    - jump_control = 00, target_addr = 0, ras_pred_valid = 0, mispredict = 0.
    - No RAS action. The result is still passed through.
  - link_addr = pc + 4 for every accepted instruction.
  - All arithmetic is modulo 2^XLEN.
- RAS actions, evaluated at accept. A link register is x1 or x5; rs1 = ic[19:15].
  - JAL, rd is a link register: push.
  - JALR, rd link, rs1 not link: push.
  - JALR, rd not link, rs1 link: pop.
  - JALR, rd and rs1 both link and equal: push.
  - JALR, rd and rs1 both link and different: pop then push. The prediction is taken from the old top; the top entry is overwritten with link_addr; count is unchanged.
  - Any other case: no action.
- RAS boundaries:
  - Push when full: the circular pointer overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: ras_pred_valid = 0; pointer and count are unchanged.
  - Pop when non-empty: ras_pred_valid = 1, ras_pred_addr = top entry; pointer and count both decrement.
  - ras_pred_addr = 0 whenever ras_pred_valid = 0.
- mispredict is registered with the rest of the result: mispredict = ras_pred_valid && (ras_pred_addr != target_addr).

Test Plan:
1. Basic call and return, XLEN=32.
   - Accept 0x008000EF (jal x1,+8) at pc=0x100. Next cycle: out_valid=1, jump_control=01, rd=1, target=0x108, link=0x104, ras_pred_valid=0; RAS count=1.
   - Then accept 0x00008067 (jalr x0,0(x1)) with rs1_data=0x104. Result: jump_control=10, target=0x104, ras_pred_valid=1, pred=0x104, mispredict=0; RAS count=0.
2. Return mismatch and JALR alignment.
   - Push 0x104, then jalr x0,0(x1) with rs1_data=0x201.
   - Result: target=0x200, pred=0x104, mispredict=1.
3. RAS overflow and underflow, RAS_DEPTH=4.
   - Five JAL x1 at pc=0x0,0x10,0x20,0x30,0x40.
   - Five returns. First four predict 0x44, 0x34, 0x24, 0x14. Fifth gives ras_pred_valid=0, pred_addr=0.
4. Backpressure.
   - Hold out_ready=0 for 3 cycles after an accept.
   - Required: in_ready=0 and outputs stable throughout. When out_ready rises with a new in_valid, the next result appears the following cycle with no bubble.
5. Flush and reset.
   - Assert flush while out_valid=1 and in_valid=1. Next cycle: out_valid=0; the new instruction is not accepted; RAS count unchanged.
   - Drop rst_n asynchronously mid-hold. Required: immediately out_valid=0 and all outputs 0; RAS empty after release.
6. Non-jump pass-through and coroutine swap.
   - 0x00000033 (add) gives jump_control=00, link=pc+4, no RAS change.
   - jalr x1,0(x5) on a one-entry RAS holding 0x500, at pc=0x600, with rs1_data=0x500. Result: pred=0x500, mispredict=0, RAS top becomes 0x604, count stays 1.
